alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_rsp_fifo.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices and FSM state shared by the ALU issue path.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGT = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;
  localparam int OP_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Subtract-style ops (bit 2 or 3 set) need the +1 of two's-complement negate
  function automatic logic cin_of(logic [3:0] op);
    return op[3] | op[2];
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: small response queue, head shown combinationally.
`timescale 1ns/1ps
module alu_rsp_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i & (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i & (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= inc(rd_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign empty_o = (cnt_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers one request into the ALU, captures its
// result into a response FIFO and tracks overflow statistics.
`timescale 1ns/1ps
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       ALU_cont,
  output logic             Cin,
  input  logic [WIDTH-1:0] X,
  input  logic             Cout,
  input  logic             Zero,
  input  logic             Overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_x,
  output logic [2:0]       rsp_flags,
  output logic [3:0]       rsp_op,
  output logic             ov_sticky,
  input  logic             sticky_clr,
  output logic [7:0]       ov_count
);

  localparam int DW = WIDTH + FLAG_W + OP_W;
  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             ov_q, ov_d;
  logic [7:0]       ovc_q, ovc_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic             empty;
  logic [CW-1:0]    count;
  logic [2:0]       flags;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rdata;

  assign req_ready = (state_q == IDLE) & (count < CW'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign push      = (state_q == EXEC);
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
        end
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A clear in the same cycle as an overflow push takes priority
  always_comb begin
    ov_d  = ov_q;
    ovc_d = ovc_q;
    if (sticky_clr) begin
      ov_d  = 1'b0;
      ovc_d = '0;
    end else if (push && Overflow) begin
      ov_d = 1'b1;
      if (ovc_q != 8'hFF) begin
        ovc_d = ovc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ov_q    <= 1'b0;
      ovc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ov_q    <= ov_d;
      ovc_q   <= ovc_d;
    end
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_V] = Overflow;
    flags[FLAG_C] = Cout;
    flags[FLAG_Z] = Zero;
  end

  assign wdata = {X, flags, op_q};

  alu_rsp_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .empty_o (empty),
    .count_o (count)
  );

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_cont  = op_q;
  assign Cin       = cin_of(op_q);
  assign rsp_valid = ~empty;
  assign rsp_x     = rdata[DW-1 -: WIDTH];
  assign rsp_flags = rdata[OP_W +: FLAG_W];
  assign rsp_op    = rdata[OP_W-1:0];
  assign ov_sticky = ov_q;
  assign ov_count  = ovc_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl with a
// behavioural 4-bit ALU closing the loop.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALU_cont;
  logic         Cin;
  logic [W-1:0] X;
  logic         Cout;
  logic         Zero;
  logic         Overflow;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_x;
  logic [2:0]   rsp_flags;
  logic [3:0]   rsp_op;
  logic         ov_sticky;
  logic         sticky_clr;
  logic [7:0]   ov_count;

  int n_chk;
  int n_err;

  logic [10:0] got_q[$];
  logic [4:0]  s;

  alu_issue_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .A          (A),
    .B          (B),
    .ALU_cont   (ALU_cont),
    .Cin        (Cin),
    .X          (X),
    .Cout       (Cout),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_x      (rsp_x),
    .rsp_flags  (rsp_flags),
    .rsp_op     (rsp_op),
    .ov_sticky  (ov_sticky),
    .sticky_clr (sticky_clr),
    .ov_count   (ov_count)
  );

  initial clk = 1'b0;
  always #0.5 clk = ~clk;

  // Team ALU: compares report 0/1, never overflow
  always_comb begin
    s        = '0;
    X        = '0;
    Cout     = 1'b0;
    Overflow = 1'b0;
    case (ALU_cont)
      OP_AND: X = A & B;
      OP_OR:  X = A | B;
      OP_NOR: X = ~(A | B);
      OP_ADD: begin
        s        = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
        X        = s[3:0];
        Cout     = s[4];
        Overflow = (A[3] == B[3]) && (s[3] != A[3]);
      end
      OP_SUB: begin
        s        = {1'b0, A} + {1'b0, ~B} + {4'b0, Cin};
        X        = s[3:0];
        Cout     = s[4];
        Overflow = (A[3] != B[3]) && (s[3] != A[3]);
      end
      OP_SLT: begin
        s    = {1'b0, A} + {1'b0, ~B} + {4'b0, Cin};
        Cout = s[4];
        X    = {3'b0, s[3] ^ ((A[3] != B[3]) && (s[3] != A[3]))};
      end
      OP_SGT: begin
        s    = {1'b0, B} + {1'b0, ~A} + {4'b0, Cin};
        Cout = s[4];
        X    = {3'b0, s[3] ^ ((B[3] != A[3]) && (s[3] != B[3]))};
      end
      default: X = '0;
    endcase
  end
  assign Zero = (X == '0);

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_x, rsp_flags, rsp_op});
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #0.1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic rdy;
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    for (int t = 0; t < 20; t++) begin
      rdy = req_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("accept", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;
    sticky_clr = 1'b0;
    #0.2 rst_n = 1'b0;
    #0.1;
    check("rst_valid", {31'b0, rsp_valid}, 0);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_ops", {20'b0, A, B, ALU_cont}, 0);
    check("rst_cin", {31'b0, Cin}, 0);
    check("rst_rsp", {21'b0, rsp_x, rsp_flags, rsp_op}, 0);
    check("rst_ov", {23'b0, ov_sticky, ov_count}, 0);
    step();
    step();
    rst_n = 1'b1;

    // 7 + 1 overflows to -8
    issue(OP_ADD, 4'd7, 4'd1);
    check("add_ops", {20'b0, A, B, ALU_cont}, {20'b0, 4'd7, 4'd1, OP_ADD});
    check("add_cin", {31'b0, Cin}, 0);
    check("add_busy", {31'b0, req_ready}, 0);
    check("add_lat", {31'b0, rsp_valid}, 0);
    step();
    check("add_vld", {31'b0, rsp_valid}, 1);
    check("add_x", {28'b0, rsp_x}, 32'h8);
    check("add_fl", {29'b0, rsp_flags}, 32'b100);
    check("add_op", {28'b0, rsp_op}, {28'b0, OP_ADD});
    check("add_stk", {31'b0, ov_sticky}, 1);
    check("add_cnt", {24'b0, ov_count}, 1);
    step();
    check("add_pop", {31'b0, rsp_valid}, 0);

    // -3 vs 7 both ways
    issue(OP_SLT, 4'b1101, 4'b0111);
    check("slt_cin", {31'b0, Cin}, 1);
    step();
    check("slt_x", {28'b0, rsp_x}, 32'h1);
    check("slt_fl", {29'b0, rsp_flags}, 32'b010);
    check("slt_op", {28'b0, rsp_op}, {28'b0, OP_SLT});
    step();
    issue(OP_SGT, 4'b1101, 4'b0111);
    check("sgt_cin", {31'b0, Cin}, 1);
    step();
    check("sgt_x", {28'b0, rsp_x}, 32'h0);
    check("sgt_fl", {29'b0, rsp_flags}, 32'b001);
    check("sgt_op", {28'b0, rsp_op}, {28'b0, OP_SGT});
    check("cmp_cnt", {24'b0, ov_count}, 1);
    step();

    // Backpressure with a two-entry queue
    rsp_ready = 1'b0;
    got_q.delete();
    issue(OP_ADD, 4'd1, 4'd2);
    step();
    issue(OP_SUB, 4'd5, 4'd3);
    step();
    check("bp_full", {31'b0, req_ready}, 0);
    req_valid = 1'b1;
    req_op    = OP_OR;
    req_a     = 4'd4;
    req_b     = 4'd1;
    step();
    step();
    check("bp_hold_rdy", {31'b0, req_ready}, 0);
    check("bp_hold_vld", {31'b0, rsp_valid}, 1);
    check("bp_hold_x", {28'b0, rsp_x}, 32'h3);
    check("bp_hold_op", {28'b0, rsp_op}, {28'b0, OP_ADD});
    rsp_ready = 1'b1;
    issue(OP_OR, 4'd4, 4'd1);
    for (int t = 0; t < 20 && got_q.size() < 3; t++) begin
      step();
    end
    check("bp_n", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      check("bp_r0", {21'b0, got_q[0]}, {21'b0, 4'd3, 3'b000, OP_ADD});
      check("bp_r1", {21'b0, got_q[1]}, {21'b0, 4'd2, 3'b010, OP_SUB});
      check("bp_r2", {21'b0, got_q[2]}, {21'b0, 4'd5, 3'b000, OP_OR});
    end
    step();

    // Reset while the operation is in EXEC
    issue(OP_ADD, 4'd3, 4'd3);
    rst_n = 1'b0;
    #0.1;
    check("mid_ops", {20'b0, A, B, ALU_cont}, 0);
    check("mid_cin", {31'b0, Cin}, 0);
    check("mid_vld", {31'b0, rsp_valid}, 0);
    step();
    check("mid_vld2", {31'b0, rsp_valid}, 0);
    check("mid_rsp", {21'b0, rsp_x, rsp_flags, rsp_op}, 0);
    check("mid_ov", {23'b0, ov_sticky, ov_count}, 0);
    rst_n = 1'b1;
    step();
    check("mid_empty", {31'b0, rsp_valid}, 0);
    issue(OP_ADD, 4'd2, 4'd3);
    step();
    check("mid_next_vld", {31'b0, rsp_valid}, 1);
    check("mid_next_x", {28'b0, rsp_x}, 32'h5);
    check("mid_next_fl", {29'b0, rsp_flags}, 32'b000);
    step();

    // Counter saturation, then clear racing an overflow push
    for (int i = 0; i < 255; i++) begin
      issue(OP_ADD, 4'd7, 4'd1);
    end
    step();
    check("sat_255", {24'b0, ov_count}, 255);
    for (int i = 0; i < 5; i++) begin
      issue(OP_ADD, 4'd7, 4'd1);
    end
    step();
    check("sat_260", {24'b0, ov_count}, 255);
    check("sat_stk", {31'b0, ov_sticky}, 1);
    issue(OP_ADD, 4'd7, 4'd1);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("clr_cnt", {24'b0, ov_count}, 0);
    check("clr_stk", {31'b0, ov_sticky}, 0);
    issue(OP_ADD, 4'd7, 4'd1);
    step();
    check("clr_inc", {24'b0, ov_count}, 1);
    check("clr_set", {31'b0, ov_sticky}, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
